ahb_lite_mem_slave: RTL and testbench

AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

---
 rtl/ahb_lite_mem_slave.sv | 168 ++++++++++++++++
 tb/tb_ahb_lite_mem_slave.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite word-organised memory slave with byte-lane writes, optional wait states
// and a two-cycle ERROR response for bad or injected transfers.
module ahb_lite_mem_slave #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned RW          = 1,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic [1:0]    htrans,
  input  logic          hmastlock,
  input  logic [DW-1:0] hwdata,
  input  logic          error,
  output logic          hready,
  output logic [RW-1:0] hresp,
  output logic [DW-1:0] hrdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NB    = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic              hready_q;
  logic [RW-1:0]     hresp_q;
  logic [DW-1:0]     hrdata_q;
  logic              ph_valid_q;
  logic              ph_write_q;
  logic [IDX_W-1:0]  ph_idx_q;
  logic [NB-1:0]     ph_be_q;
  logic [DW-1:0]     mem_q [DEPTH];

  logic              addr_phase_c;
  logic              xfer_err_c;
  logic              accept_c;
  logic [NB-1:0]     be_c;
  logic [IDX_W-1:0]  new_idx_c;
  logic              wr_en_c;
  logic [DW-1:0]     wr_word_c;
  logic              rd_hit_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic [DW-1:0]     rd_word_c;
  logic              unused_c;

  assign unused_c = ^{hburst, hprot, hmastlock};

  assign hready = hready_q;
  assign hresp  = hresp_q;
  assign hrdata = hrdata_q;

  // Address-phase qualification and error classification
  assign addr_phase_c = hsel & hready_q & htrans[1];
  assign xfer_err_c   = ({2'b00, haddr[AW-1:2]} >= AW'(DEPTH))
                      | (hsize > 3'b010)
                      | ((hsize == 3'b001) & haddr[0])
                      | ((hsize == 3'b010) & (haddr[1:0] != 2'b00))
                      | error;
  assign accept_c     = addr_phase_c & ~xfer_err_c;
  assign new_idx_c    = haddr[IDX_W+1:2];

  always_comb begin
    be_c = 4'b1111;
    case (hsize[1:0])
      2'b00:   be_c = 4'b0001 << haddr[1:0];
      2'b01:   be_c = haddr[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
  end

  // Write lands on the edge that ends the data phase (hready high)
  assign wr_en_c = ph_valid_q & ph_write_q & hready_q;

  always_comb begin
    wr_word_c = mem_q[ph_idx_q];
    for (int i = 0; i < NB; i++) begin
      if (ph_be_q[i]) wr_word_c[8*i +: 8] = hwdata[8*i +: 8];
    end
  end

  // Read data for the coming completion cycle, forwarding a same-edge write
  always_comb begin
    rd_hit_c  = 1'b0;
    rd_idx_c  = ph_idx_q;
    rd_word_c = '0;
    if (WAIT_STATES == 0 && accept_c && !hwrite) begin
      rd_hit_c = 1'b1;
      rd_idx_c = new_idx_c;
    end else if (state_q == S_WAIT && cnt_q == 3'd0 && ph_valid_q && !ph_write_q) begin
      rd_hit_c = 1'b1;
    end
    if (rd_hit_c) begin
      rd_word_c = (wr_en_c && rd_idx_c == ph_idx_q) ? wr_word_c : mem_q[rd_idx_c];
    end
  end

  always_ff @(posedge hclk) begin
    if (wr_en_c) mem_q[ph_idx_q] <= wr_word_c;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      hready_q   <= 1'b1;
      hresp_q    <= '0;
      hrdata_q   <= '0;
      ph_valid_q <= 1'b0;
      ph_write_q <= 1'b0;
      ph_idx_q   <= '0;
      ph_be_q    <= '0;
    end else begin
      hrdata_q <= rd_word_c;
      case (state_q)
        S_IDLE, S_ERR2: begin
          ph_valid_q <= accept_c;
          if (accept_c) begin
            ph_write_q <= hwrite;
            ph_idx_q   <= new_idx_c;
            ph_be_q    <= be_c;
          end
          if (addr_phase_c && xfer_err_c) begin
            state_q  <= S_ERR1;
            hready_q <= 1'b0;
            hresp_q  <= RW'(1);
          end else if (accept_c && WAIT_STATES > 0) begin
            state_q  <= S_WAIT;
            cnt_q    <= 3'(WAIT_STATES - 1);
            hready_q <= 1'b0;
            hresp_q  <= '0;
          end else begin
            state_q  <= S_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= '0;
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            state_q  <= S_IDLE;
            hready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= RW'(1);
        end
        default: begin
          state_q  <= S_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Directed bench for ahb_lite_mem_slave: three instances (0, 2 and 3 wait states)
// share one bus; each scenario checks the instance selected by dsel.
module tb_ahb_lite_mem_slave;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        error;

  logic        hready0, hready2, hready3;
  logic [0:0]  hresp0, hresp2, hresp3;
  logic [31:0] hrdata0, hrdata2, hrdata3;

  int total = 0;
  int bad   = 0;
  int dsel  = 0;

  logic        c_hready;
  logic        c_hresp;
  logic [31:0] c_hrdata;

  always #5 hclk = ~hclk;

  ahb_lite_mem_slave #(.WAIT_STATES(0)) u0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
    .hmastlock(hmastlock), .hwdata(hwdata), .error(error),
    .hready(hready0), .hresp(hresp0), .hrdata(hrdata0));

  ahb_lite_mem_slave #(.WAIT_STATES(2)) u2 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
    .hmastlock(hmastlock), .hwdata(hwdata), .error(error),
    .hready(hready2), .hresp(hresp2), .hrdata(hrdata2));

  ahb_lite_mem_slave #(.WAIT_STATES(3)) u3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans),
    .hmastlock(hmastlock), .hwdata(hwdata), .error(error),
    .hready(hready3), .hresp(hresp3), .hrdata(hrdata3));

  always_comb begin
    c_hready = hready0;
    c_hresp  = hresp0[0];
    c_hrdata = hrdata0;
    if (dsel == 2) begin
      c_hready = hready2;
      c_hresp  = hresp2[0];
      c_hrdata = hrdata2;
    end else if (dsel == 3) begin
      c_hready = hready3;
      c_hresp  = hresp3[0];
      c_hrdata = hrdata3;
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'b000;
    haddr  = 32'h0;
    error  = 1'b0;
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] s, input logic e);
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = s;
    error  = e;
  endtask

  task automatic settle();
    bus_idle();
    repeat (5) tick();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d,
                          output int waits);
    addr_ph(a, 1'b1, s, 1'b0);
    tick();
    bus_idle();
    hwdata = d;
    waits  = 0;
    while (!c_hready && waits < 20) begin
      tick();
      waits++;
    end
    total++;
    if (c_hready !== 1'b1) begin
      bad++;
      $display("FAIL write_timeout addr=%h hready=%b required=1", a, c_hready);
    end
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic r,
                         output int waits);
    addr_ph(a, 1'b0, 3'b010, 1'b0);
    tick();
    bus_idle();
    waits = 0;
    while (!c_hready && waits < 20) begin
      tick();
      waits++;
    end
    total++;
    if (c_hready !== 1'b1) begin
      bad++;
      $display("FAIL read_timeout addr=%h hready=%b required=1", a, c_hready);
    end
    d = c_hrdata;
    r = c_hresp;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        r;
    int          w;
    dsel      = 0;
    hresetn   = 1'b0;
    hwdata    = 32'h0;
    hburst    = 3'b000;
    hprot     = 4'b0011;
    hmastlock = 1'b0;
    bus_idle();
    repeat (2) tick();
    total++; if (hready0 !== 1'b1) begin bad++; $display("FAIL reset_hready got=%b exp=1", hready0); end
    total++; if (hresp0 !== 1'b0) begin bad++; $display("FAIL reset_hresp got=%b exp=0", hresp0); end
    total++; if (hrdata0 !== 32'h0) begin bad++; $display("FAIL reset_hrdata got=%h exp=0", hrdata0); end
    total++; if (hready3 !== 1'b1) begin bad++; $display("FAIL reset_hready3 got=%b exp=1", hready3); end
    hresetn = 1'b1;
    // first address phase is presented right after deassertion
    do_write(32'h8, 3'b010, 32'h01020304, w);
    do_read(32'h8, d, r, w);
    total++; if (d !== 32'h01020304) begin bad++; $display("FAIL first_after_reset got=%h exp=01020304", d); end
    total++; if (w !== 0) begin bad++; $display("FAIL first_after_reset_waits got=%0d exp=0", w); end
  endtask

  task automatic test_back_to_back();
    dsel = 0;
    settle();
    addr_ph(32'h10, 1'b1, 3'b010, 1'b0);
    tick();
    hwdata = 32'hDEADBEEF;
    addr_ph(32'h10, 1'b0, 3'b010, 1'b0);
    total++; if (c_hready !== 1'b1) begin bad++; $display("FAIL b2b_wr_hready got=%b exp=1", c_hready); end
    tick();
    bus_idle();
    total++; if (c_hready !== 1'b1) begin bad++; $display("FAIL b2b_rd_hready got=%b exp=1", c_hready); end
    total++; if (c_hrdata !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_rd_data got=%h exp=deadbeef", c_hrdata); end
    total++; if (c_hresp !== 1'b0) begin bad++; $display("FAIL b2b_rd_hresp got=%b exp=0", c_hresp); end
    tick();
    total++; if (c_hrdata !== 32'h0) begin bad++; $display("FAIL b2b_idle_data got=%h exp=0", c_hrdata); end
  endtask

  task automatic test_wait_states();
    int w;
    dsel = 2;
    settle();
    do_write(32'h0, 3'b010, 32'hCAFE0001, w);
    total++; if (w !== 2) begin bad++; $display("FAIL ws2_write_waits got=%0d exp=2", w); end
    addr_ph(32'h0, 1'b0, 3'b010, 1'b0);
    tick();
    bus_idle();
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({c_hready, c_hresp} !== 2'b00) begin
        bad++;
        $display("FAIL ws2_wait%0d hready,hresp got=%b exp=00", i, {c_hready, c_hresp});
      end
      tick();
    end
    total++; if (c_hready !== 1'b1) begin bad++; $display("FAIL ws2_done_hready got=%b exp=1", c_hready); end
    total++; if (c_hrdata !== 32'hCAFE0001) begin bad++; $display("FAIL ws2_rdata got=%h exp=cafe0001", c_hrdata); end
    total++; if (c_hresp !== 1'b0) begin bad++; $display("FAIL ws2_hresp got=%b exp=0", c_hresp); end
    tick();
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    logic        r;
    int          w;
    dsel = 0;
    settle();
    do_write(32'h20, 3'b010, 32'h00000000, w);
    do_write(32'h21, 3'b000, 32'h0000AB00, w);
    do_write(32'h22, 3'b001, 32'h12340000, w);
    do_read(32'h20, d, r, w);
    total++; if (d !== 32'h1234AB00) begin bad++; $display("FAIL lanes_mix got=%h exp=1234ab00", d); end
    do_write(32'h23, 3'b000, 32'hEF000000, w);
    do_read(32'h20, d, r, w);
    total++; if (d !== 32'hEF34AB00) begin bad++; $display("FAIL lanes_byte3 got=%h exp=ef34ab00", d); end
    do_write(32'h20, 3'b001, 32'hFFFF5678, w);
    do_read(32'h20, d, r, w);
    total++; if (d !== 32'hEF345678) begin bad++; $display("FAIL lanes_half0 got=%h exp=ef345678", d); end
  endtask

  task automatic test_errors();
    logic [31:0] ea [5] = '{32'h400, 32'h02, 32'h30, 32'h01, 32'h04};
    logic        ew [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  es [5] = '{3'b010, 3'b010, 3'b010, 3'b001, 3'b011};
    logic        ee [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] d;
    logic        r;
    int          w;
    dsel = 0;
    settle();
    do_write(32'h00, 3'b010, 32'h11223344, w);
    do_write(32'h30, 3'b010, 32'h30303030, w);
    for (int i = 0; i < 5; i++) begin
      addr_ph(ea[i], ew[i], es[i], ee[i]);
      tick();
      bus_idle();
      hwdata = 32'hFFFFFFFF;
      total++;
      if ({c_hready, c_hresp} !== 2'b01) begin
        bad++; $display("FAIL err%0d_cycle1 hready,hresp got=%b exp=01", i, {c_hready, c_hresp});
      end
      tick();
      total++;
      if ({c_hready, c_hresp} !== 2'b11) begin
        bad++; $display("FAIL err%0d_cycle2 hready,hresp got=%b exp=11", i, {c_hready, c_hresp});
      end
      tick();
      total++;
      if ({c_hready, c_hresp} !== 2'b10) begin
        bad++; $display("FAIL err%0d_after hready,hresp got=%b exp=10", i, {c_hready, c_hresp});
      end
    end
    do_read(32'h00, d, r, w);
    total++; if (d !== 32'h11223344) begin bad++; $display("FAIL err_mem0 got=%h exp=11223344", d); end
    do_read(32'h30, d, r, w);
    total++; if (d !== 32'h30303030) begin bad++; $display("FAIL err_mem30 got=%h exp=30303030", d); end
  endtask

  task automatic test_err_pipeline();
    dsel = 0;
    settle();
    addr_ph(32'h400, 1'b0, 3'b010, 1'b0);
    tick();
    bus_idle();
    tick();
    // new read presented in the second ERROR cycle
    addr_ph(32'h00, 1'b0, 3'b010, 1'b0);
    total++; if ({c_hready, c_hresp} !== 2'b11) begin bad++; $display("FAIL errpipe_err2 got=%b exp=11", {c_hready, c_hresp}); end
    tick();
    bus_idle();
    total++; if ({c_hready, c_hresp} !== 2'b10) begin bad++; $display("FAIL errpipe_done got=%b exp=10", {c_hready, c_hresp}); end
    total++; if (c_hrdata !== 32'h11223344) begin bad++; $display("FAIL errpipe_rdata got=%h exp=11223344", c_hrdata); end
    tick();
  endtask

  task automatic test_idle_busy();
    logic       cs [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] ct [3] = '{2'b00, 2'b01, 2'b10};
    logic [31:0] d;
    logic        r;
    int          w;
    dsel = 0;
    settle();
    for (int i = 0; i < 3; i++) begin
      hsel   = cs[i];
      htrans = ct[i];
      haddr  = 32'h30;
      hwrite = 1'b1;
      hsize  = 3'b010;
      tick();
      bus_idle();
      hwdata = 32'hFFFFFFFF;
      total++;
      if ({c_hready, c_hresp} !== 2'b10) begin
        bad++; $display("FAIL idle%0d hready,hresp got=%b exp=10", i, {c_hready, c_hresp});
      end
      tick();
    end
    do_read(32'h30, d, r, w);
    total++; if (d !== 32'h30303030) begin bad++; $display("FAIL idle_mem30 got=%h exp=30303030", d); end
    total++; if (r !== 1'b0) begin bad++; $display("FAIL idle_rd_hresp got=%b exp=0", r); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] d;
    logic        r;
    int          w;
    dsel = 3;
    settle();
    do_write(32'h40, 3'b010, 32'hAAAA5555, w);
    total++; if (w !== 3) begin bad++; $display("FAIL ws3_write_waits got=%0d exp=3", w); end
    addr_ph(32'h40, 1'b1, 3'b010, 1'b0);
    tick();
    bus_idle();
    hwdata = 32'h12345678;
    total++; if (c_hready !== 1'b0) begin bad++; $display("FAIL ws3_in_wait got=%b exp=0", c_hready); end
    tick();
    #1 hresetn = 1'b0;
    #1;
    total++; if ({c_hready, c_hresp} !== 2'b10) begin bad++; $display("FAIL midwait_reset got=%b exp=10", {c_hready, c_hresp}); end
    #1 hresetn = 1'b1;
    do_read(32'h40, d, r, w);
    total++; if (d !== 32'hAAAA5555) begin bad++; $display("FAIL midwait_mem got=%h exp=aaaa5555", d); end
    total++; if (w !== 3) begin bad++; $display("FAIL midwait_rd_waits got=%0d exp=3", w); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_byte_lanes();
    test_errors();
    test_err_pipeline();
    test_idle_busy();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
